// File: rtl/cfg_latch_loader_pkg.sv
// rtl/cfg_latch_loader_pkg.sv - shared types and constants for the config latch loader
//
// Purpose: FSM state encoding, default geometry and sizing helpers used by
//          cfg_latch_loader and cfg_word_assembler.
// Ports:   none (package).
package cfg_latch_loader_pkg;

  localparam int DEF_NUM_WORDS = 10;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_IN_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Input beats per latch word.
  function automatic int beats_of(input int word_w, input int in_w);
    return word_w / in_w;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int idx_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// rtl/cfg_word_assembler.sv - packs input beats into one latch word, first beat least significant
//
// Purpose: beat counter plus byte-lane word register.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_clear       restart assembly at lane 0 (start of a load)
//   i_accept      a beat is being accepted this cycle
//   i_data        beat payload
//   o_word_full   the beat currently offered completes the word
//   o_word        assembled word including the beat currently offered
module cfg_word_assembler
  import cfg_latch_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IN_W   = DEF_IN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_word_full,
  output logic [WORD_W-1:0] o_word
);

  localparam int BEATS = beats_of(WORD_W, IN_W);
  localparam int CNT_W = idx_w_of(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  r_beat_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word;

  // Merging the live beat lets the top register the finished word on the
  // same edge that accepts the last beat, so SETUP already shows it.
  always_comb begin
    w_word = r_word;
    w_word[r_beat_cnt*IN_W +: IN_W] = i_data;
  end

  assign o_word_full = (r_beat_cnt == LAST_BEAT);
  assign o_word      = w_word;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_beat_cnt <= '0;
      r_word     <= '0;
    end else if (i_accept) begin
      r_word     <= w_word;
      r_beat_cnt <= o_word_full ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfg_latch_loader.sv
// rtl/cfg_latch_loader.sv - loads a LUT tile latch bank from a byte-wide config stream
//
// Purpose: assembles beats into words and writes each word with a
//          setup / strobe / hold sequence, word 0 first.
// Optional: CFG_LATCH_LOADER_CHECKSUM_EN adds an XOR trailer check (CHECK state).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   io_start         pulse; begins a full load when not busy
//   io_in_valid/ready/data  beat handshake (accept on valid && ready)
//   io_d_in          latch data bus
//   io_configs_en    one-hot latch word enables
//   io_busy          load in progress
//   io_done          sticky, last load completed; cleared by io_start
//   io_cfg_err       sticky checksum error (0 without the option)
module cfg_latch_loader
  import cfg_latch_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int IN_W      = DEF_IN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [IN_W-1:0]      io_in_data,
  output logic [WORD_W-1:0]    io_d_in,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_cfg_err
);

  localparam int IDX_W = idx_w_of(NUM_WORDS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_word_idx;
  logic                 r_in_ready;
  logic [WORD_W-1:0]    r_d_in;
  logic [NUM_WORDS-1:0] r_configs_en;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_start_ok;
  logic                 w_load_beat;
  logic                 w_word_full;
  logic [WORD_W-1:0]    w_word;

  // DONE is a one-cycle state with busy already low, so a start there is honoured.
  assign w_start_ok  = io_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_load_beat = io_in_valid && r_in_ready && (r_state == ST_LOAD);

  cfg_word_assembler #(
    .WORD_W (WORD_W),
    .IN_W   (IN_W)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_ok),
    .i_accept    (w_load_beat),
    .i_data      (io_in_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
  logic [IN_W-1:0] r_xor;
  logic            r_cfg_err;
  logic            w_check_beat;

  assign w_check_beat = io_in_valid && r_in_ready && (r_state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_xor     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (w_load_beat)  r_xor     <= r_xor ^ io_in_data;
      if (w_check_beat) r_cfg_err <= (io_in_data != r_xor);
    end
  end

  assign io_cfg_err = r_cfg_err;
`else
  assign io_cfg_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_word_idx   <= '0;
      r_in_ready   <= 1'b0;
      r_d_in       <= '0;
      r_configs_en <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state    <= ST_LOAD;
            r_word_idx <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (w_load_beat && w_word_full) begin
            // Data bus moves only here, a full cycle ahead of the enable.
            r_d_in     <= w_word;
            r_in_ready <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_configs_en <= EN_ONE << r_word_idx;
          r_state      <= ST_STROBE;
        end
        ST_STROBE: begin
          r_configs_en <= '0;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_word_idx == LAST_IDX) begin
`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
            r_in_ready <= 1'b1;
            r_state    <= ST_CHECK;
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
`endif
          end else begin
            r_word_idx <= r_word_idx + IDX_W'(1);
            r_in_ready <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_check_beat) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_in_ready   = r_in_ready;
  assign io_d_in       = r_d_in;
  assign io_configs_en = r_configs_en;
  assign io_busy       = r_busy;
  assign io_done       = r_done;

endmodule

// File: tb/tb_cfg_latch_loader.sv
// tb/tb_cfg_latch_loader.sv - self-checking bench for cfg_latch_loader
module tb_cfg_latch_loader;

  localparam int NW    = 10;
  localparam int WW    = 32;
  localparam int IW    = 8;
  localparam int BEATS = WW / IW;
`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
  localparam int EXP_LAT = NW * (BEATS + 3) + 1;
`else
  localparam int EXP_LAT = NW * (BEATS + 3);
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_start = 1'b0;
  logic          io_in_valid = 1'b0;
  logic          io_in_ready;
  logic [IW-1:0] io_in_data = '0;
  logic [WW-1:0] io_d_in;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
  logic          io_cfg_err;

  cfg_latch_loader #(.NUM_WORDS(NW), .WORD_W(WW), .IN_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_data    (io_in_data),
    .io_d_in       (io_d_in),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_cfg_err    (io_cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t_start = 0;

  logic [IW-1:0] stream[$];
  logic [NW-1:0] cap_en[$];
  logic [WW-1:0] cap_d[$];
  int            viol = 0;
  logic [NW-1:0] p_en = '0;
  logic [WW-1:0] p_d = '0;
  logic          p_ready = 1'b0;

  // Latch-timing watcher: records every strobe and counts rule breaks.
  always @(negedge clk) begin
    if ($countones(io_configs_en) > 1) viol++;
    if (io_configs_en != '0) begin
      if (p_en != '0) viol++;
      if (io_d_in !== p_d) viol++;
      if (io_in_ready || p_ready) viol++;
      cap_en.push_back(io_configs_en);
      cap_d.push_back(io_d_in);
    end else if (p_en != '0) begin
      if (io_d_in !== p_d) viol++;
      if (io_in_ready) viol++;
    end
    p_en    = io_configs_en;
    p_d     = io_d_in;
    p_ready = io_in_ready;
  end

  function automatic logic [WW-1:0] exp_word(input int k);
    logic [WW-1:0] w = '0;
    for (int j = 0; j < BEATS; j++) w[j*IW +: IW] = stream[k*BEATS + j];
    return w;
  endfunction

  function automatic logic [IW-1:0] exp_xor();
    logic [IW-1:0] x = '0;
    for (int i = 0; i < NW * BEATS; i++) x ^= stream[i];
    return x;
  endfunction

  task automatic build_stream(input bit incr, input bit bad_trailer);
    logic [IW-1:0] t;
    stream.delete();
    for (int i = 0; i < NW * BEATS; i++) stream.push_back(incr ? IW'(i) : IW'($urandom));
`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
    t = exp_xor();
    if (bad_trailer) t ^= IW'(1) << $urandom_range(0, IW - 1);
    stream.push_back(t);
`else
    t = IW'(bad_trailer);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cap_en.delete();
    cap_d.delete();
    viol = 0;
    io_start = 1'b1;
  endtask

  // Streams the beats; optionally pulses start again once mid-load and
  // stops early once stop_caps strobes have been seen.
  task automatic send(input bit gaps, input int restart_at, input int stop_caps, output int sent);
    int  idx = 0;
    int  guard = 0;
    bit  first = 1'b1;
    bit  pulsed = 1'b0;
    while (idx < stream.size() && cap_en.size() < stop_caps && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (first) begin
        t_start = cyc;
        first = 1'b0;
      end
      io_start = 1'b0;
      if (!pulsed && restart_at >= 0 && idx == restart_at) begin
        io_start = 1'b1;
        pulsed = 1'b1;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        io_in_valid = 1'b0;
        io_in_data  = IW'($urandom);
      end else begin
        io_in_valid = 1'b1;
        io_in_data  = stream[idx];
      end
      if (io_in_valid && io_in_ready) idx++;
    end
    @(negedge clk);
    io_in_valid = 1'b0;
    io_start = 1'b0;
    sent = idx;
  endtask

  task automatic finish_load(input string tag, input bit chk_lat, input bit exp_err);
    int g = 0;
    int lat;
    while (!io_done && g < 300) begin
      @(negedge clk);
      g++;
    end
    lat = cyc - t_start;
    n_cmp++;
    if (io_done !== 1'b1) begin n_bad++; $display("FAIL %s done: got %b expected 1", tag, io_done); end
    n_cmp++;
    if (io_busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b expected 0", tag, io_busy); end
    if (chk_lat) begin
      n_cmp++;
      if (lat != EXP_LAT) begin n_bad++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, EXP_LAT); end
    end
    n_cmp++;
    if (io_cfg_err !== exp_err) begin n_bad++; $display("FAIL %s cfg_err: got %b expected %b", tag, io_cfg_err, exp_err); end
    n_cmp++;
    if (cap_en.size() != NW) begin n_bad++; $display("FAIL %s strobe_count: got %0d expected %0d", tag, cap_en.size(), NW); end
    for (int k = 0; k < NW && k < cap_en.size(); k++) begin
      logic [NW-1:0] one = 1;
      n_cmp++;
      if (cap_en[k] !== (one << k)) begin n_bad++; $display("FAIL %s en[%0d]: got %h expected %h", tag, k, cap_en[k], one << k); end
      n_cmp++;
      if (cap_d[k] !== exp_word(k)) begin n_bad++; $display("FAIL %s d_in[%0d]: got %h expected %h", tag, k, cap_d[k], exp_word(k)); end
    end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL %s latch_timing: got %0d violations expected 0", tag, viol); end
  endtask

  task automatic check_sent(input string tag, input int sent);
    n_cmp++;
    if (sent != stream.size()) begin n_bad++; $display("FAIL %s beats_sent: got %0d expected %0d", tag, sent, stream.size()); end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (io_configs_en !== '0) begin n_bad++; $display("FAIL %s en: got %h expected 0", tag, io_configs_en); end
    n_cmp++;
    if (io_d_in !== '0) begin n_bad++; $display("FAIL %s d_in: got %h expected 0", tag, io_d_in); end
    n_cmp++;
    if (io_in_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready: got %b expected 0", tag, io_in_ready); end
    n_cmp++;
    if (io_busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b expected 0", tag, io_busy); end
    n_cmp++;
    if (io_done !== 1'b0) begin n_bad++; $display("FAIL %s done: got %b expected 0", tag, io_done); end
    n_cmp++;
    if (io_cfg_err !== 1'b0) begin n_bad++; $display("FAIL %s err: got %b expected 0", tag, io_cfg_err); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
  endtask

  task automatic test_default_load();
    int sent;
    build_stream(1'b1, 1'b0);
    pulse_start();
    send(1'b0, -1, NW + 1, sent);
    check_sent("default", sent);
    finish_load("default", 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int sent;
    for (int r = 0; r < 2; r++) begin
      build_stream(1'b0, 1'b0);
      pulse_start();
      send(1'b1, -1, NW + 1, sent);
      check_sent("backpressure", sent);
      finish_load("backpressure", 1'b0, 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    int sent;
    build_stream(1'b0, 1'b0);
    pulse_start();
    send(1'b1, 15, NW + 1, sent);
    check_sent("start_busy", sent);
    finish_load("start_busy", 1'b0, 1'b0);
    build_stream(1'b1, 1'b0);
    pulse_start();
    @(negedge clk);
    io_start = 1'b0;
    n_cmp++;
    if (io_done !== 1'b0) begin n_bad++; $display("FAIL restart done_clear: got %b expected 0", io_done); end
    n_cmp++;
    if (io_busy !== 1'b1) begin n_bad++; $display("FAIL restart busy: got %b expected 1", io_busy); end
    send(1'b0, -1, NW + 1, sent);
    check_sent("restart", sent);
    finish_load("restart", 1'b0, 1'b0);
  endtask

  task automatic test_midload_reset();
    int sent;
    build_stream(1'b0, 1'b0);
    pulse_start();
    send(1'b0, -1, 5, sent);
    n_cmp++;
    if (cap_en.size() != 5) begin n_bad++; $display("FAIL midreset strobes_before: got %0d expected 5", cap_en.size()); end
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    build_stream(1'b0, 1'b0);
    pulse_start();
    send(1'b1, -1, NW + 1, sent);
    check_sent("after_reset", sent);
    finish_load("after_reset", 1'b0, 1'b0);
  endtask

`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int sent;
    build_stream(1'b0, 1'b1);
    pulse_start();
    send(1'b1, -1, NW + 1, sent);
    check_sent("bad_sum", sent);
    finish_load("bad_sum", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (io_cfg_err !== 1'b1) begin n_bad++; $display("FAIL bad_sum err_sticky: got %b expected 1", io_cfg_err); end
    build_stream(1'b0, 1'b0);
    pulse_start();
    @(negedge clk);
    io_start = 1'b0;
    n_cmp++;
    if (io_cfg_err !== 1'b0) begin n_bad++; $display("FAIL bad_sum err_clear: got %b expected 0", io_cfg_err); end
    send(1'b0, -1, NW + 1, sent);
    check_sent("good_sum", sent);
    finish_load("good_sum", 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_default_load();
    test_backpressure();
    test_start_while_busy();
    test_midload_reset();
`ifdef CFG_LATCH_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
